// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial sequence generators: mode field width and encodings.
package seq_gen_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_LFSR    = 2'b00,
    MODE_PATTERN = 2'b01,
    MODE_SQUARE  = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

endpackage

// File: rtl/seq_pattern_gen_lfsr_step.sv
// One combinational step of a Fibonacci LFSR: feedback is the XOR of the tapped bits,
// shifted in at the LSB.
module lfsr_step #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next,
  output logic             o_fb
);

  assign o_fb   = ^(i_state & TAPS);
  assign o_next = {i_state[WIDTH-2:0], o_fb};

endmodule

// File: rtl/seq_pattern_gen.sv
// Multi-mode serial sequence source: PRBS LFSR, rotating pattern word or square wave,
// with runtime load, lock-up recovery and a period-sync pulse.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
  parameter logic [WIDTH-1:0] SEED  = 4'b0001,
  parameter int               CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_data,
  input  logic [CNT_W-1:0]  half_period,
  output logic              OUT,
  output logic [WIDTH-1:0]  state,
  output logic              sync,
  output logic              lockup
);

  localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_state, r_seed;
  logic             r_out, r_sync, r_lockup;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_sq_cnt;
  mode_e            r_mode_q;

  logic [WIDTH-1:0] w_state_n, w_seed_n, w_lfsr_next;
  logic             w_out_n, w_sync_n, w_lockup_n, w_lfsr_fb;
  logic [BIT_W-1:0] w_bit_n, w_bit_cur;
  logic [CNT_W-1:0] w_sq_n, w_sq_cur;
  mode_e            w_mode, w_mode_q_n;
  logic             w_mode_chg;

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr_step (
    .i_state (r_state),
    .o_next  (w_lfsr_next),
    .o_fb    (w_lfsr_fb)
  );

  assign w_mode     = mode_e'(mode);
  assign w_mode_chg = (w_mode != r_mode_q);
  // A mode switch restarts the counters, and the new mode's rule sees the cleared value.
  assign w_bit_cur  = w_mode_chg ? '0 : r_bit_cnt;
  assign w_sq_cur   = w_mode_chg ? '0 : r_sq_cnt;

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    w_state_n  = r_state;
    w_seed_n   = r_seed;
    w_out_n    = r_out;
    w_sync_n   = 1'b0;
    w_lockup_n = 1'b0;
    w_bit_n    = r_bit_cnt;
    w_sq_n     = r_sq_cnt;
    w_mode_q_n = r_mode_q;

    if (load) begin
      w_state_n  = load_data;
      w_bit_n    = '0;
      w_sq_n     = '0;
      w_mode_q_n = w_mode;
      if (w_mode == MODE_LFSR) begin
        // An all-zero seed would lock the LFSR, so fall back to the built-in seed.
        w_state_n = (load_data == '0) ? SEED : load_data;
        w_seed_n  = (load_data == '0) ? SEED : load_data;
      end
    end else if (en) begin
      w_mode_q_n = w_mode;
      w_bit_n    = w_bit_cur;
      w_sq_n     = w_sq_cur;
      case (w_mode)
        MODE_LFSR: begin
          if (r_state == '0) begin
            w_state_n  = r_seed;
            w_out_n    = 1'b0;
            w_lockup_n = 1'b1;
          end else begin
            w_out_n   = r_state[WIDTH-1];
            w_state_n = w_lfsr_next;
            w_sync_n  = (w_lfsr_next == r_seed);
          end
        end
        MODE_PATTERN: begin
          w_out_n   = r_state[WIDTH-1];
          w_state_n = {r_state[WIDTH-2:0], r_state[WIDTH-1]};
          if (w_bit_cur == BIT_W'(WIDTH-1)) begin
            w_bit_n  = '0;
            w_sync_n = 1'b1;
          end else begin
            w_bit_n = w_bit_cur + 1'b1;
          end
        end
        MODE_SQUARE: begin
          // Live compare: a counter already past a shortened half_period runs on and wraps.
          if (w_sq_cur == half_period) begin
            w_sq_n   = '0;
            w_out_n  = ~r_out;
            w_sync_n = ~r_out;
          end else begin
            w_sq_n = w_sq_cur + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= SEED;
      r_seed    <= SEED;
      r_out     <= 1'b0;
      r_sync    <= 1'b0;
      r_lockup  <= 1'b0;
      r_bit_cnt <= '0;
      r_sq_cnt  <= '0;
      r_mode_q  <= MODE_LFSR;
    end else begin
      r_state   <= w_state_n;
      r_seed    <= w_seed_n;
      r_out     <= w_out_n;
      r_sync    <= w_sync_n;
      r_lockup  <= w_lockup_n;
      r_bit_cnt <= w_bit_n;
      r_sq_cnt  <= w_sq_n;
      r_mode_q  <= w_mode_q_n;
    end
  end

  assign OUT    = r_out;
  assign state  = r_state;
  assign sync   = r_sync;
  assign lockup = r_lockup;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen with hand-computed expected sequences.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_data;
  logic [7:0] half_period;
  logic       w_out;
  logic [3:0] w_state;
  logic       w_sync;
  logic       w_lockup;

  int n_checks = 0;
  int n_errors = 0;

  seq_pattern_gen dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .mode        (mode),
    .load        (load),
    .load_data   (load_data),
    .half_period (half_period),
    .OUT         (w_out),
    .state       (w_state),
    .sync        (w_sync),
    .lockup      (w_lockup)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // State after each enabled LFSR edge from seed 0001, and OUT seen after that edge.
  logic [3:0] exp_st  [15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                               4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000,
                               4'b0001};
  logic       exp_out [15] = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1};
  logic       sq_out  [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
  logic [3:0] pat_st  [8]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic       pat_out [8]  = '{1, 0, 0, 0, 1, 0, 0, 0};

  initial begin
    int early;
    reset = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; load_data = '0; half_period = '0;
    tick(); tick();
    check("rst_state", w_state, 4'b0001);
    check("rst_out", w_out, 0);
    check("rst_sync", w_sync, 0);
    check("rst_lockup", w_lockup, 0);
    reset = 1'b0;

    // LFSR free run over a full period
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("lfsr_st%0d", i), w_state, exp_st[i]);
      check($sformatf("lfsr_out%0d", i), w_out, exp_out[i]);
      check($sformatf("lfsr_sync%0d", i), w_sync, (i == 14));
    end

    // Zero load falls back to SEED; then a new seed sets the sync point
    load = 1'b1; load_data = 4'b0000;
    tick();
    check("load0_state", w_state, 4'b0001);
    check("load0_out_hold", w_out, 1);
    load_data = 4'b1010;
    tick();
    check("load_state", w_state, 4'b1010);
    load = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 0) check("reseed_first", w_state, 4'b0101);
      check($sformatf("reseed_sync%0d", i), w_sync, (i == 14));
    end
    check("reseed_return", w_state, 4'b1010);

    // PATTERN rotation
    mode = 2'b01; load = 1'b1; load_data = 4'b1000;
    tick();
    check("pat_load", w_state, 4'b1000);
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("pat_st%0d", i), w_state, pat_st[i]);
      check($sformatf("pat_out%0d", i), w_out, pat_out[i]);
      check($sformatf("pat_sync%0d", i), w_sync, (i == 3 || i == 7));
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_state", w_state, 4'b1000);
      check("hold_out", w_out, 0);
      check("hold_sync", w_sync, 0);
    end

    // Lock-up recovery: zero pattern, then switch to LFSR (seed is 1010)
    load = 1'b1; load_data = 4'b0000;
    tick();
    check("zero_pat", w_state, 4'b0000);
    load = 1'b0; mode = 2'b00; en = 1'b1;
    tick();
    check("lock_state", w_state, 4'b1010);
    check("lock_pulse", w_lockup, 1);
    check("lock_out", w_out, 0);
    tick();
    check("lock_clear", w_lockup, 0);
    check("lock_next", w_state, 4'b0101);

    // SQUARE, half_period=2, entered via load so the counter starts at 0 (OUT is 1)
    mode = 2'b10; half_period = 8'd2; load = 1'b1; load_data = 4'b0101;
    tick();
    load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("sq_out%0d", i), w_out, sq_out[i]);
      check($sformatf("sq_sync%0d", i), w_sync, (i == 5 || i == 11));
    end
    check("sq_state_hold", w_state, 4'b0101);
    half_period = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sq0_out%0d", i), w_out, (i % 2 == 1));
      check($sformatf("sq0_sync%0d", i), w_sync, (i % 2 == 1));
    end

    // Shrinking half_period below the running count: counter wraps, no early toggle
    half_period = 8'd5;
    for (int i = 0; i < 4; i++) tick();
    check("wrap_pre", w_out, 1);
    half_period = 8'd2;
    early = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (w_out !== 1'b1) early++;
    end
    check("wrap_no_early", early, 0);
    tick();
    check("wrap_toggle", w_out, 0);

    // Asynchronous reset in the middle of PATTERN
    mode = 2'b01; half_period = 8'd0; load = 1'b1; load_data = 4'b1100;
    tick();
    load = 1'b0;
    tick();
    check("pre_rst_state", w_state, 4'b1001);
    check("pre_rst_out", w_out, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", w_state, 4'b0001);
    check("async_rst_out", w_out, 0);
    #1 reset = 1'b0;
    tick();
    check("resume_state", w_state, 4'b0010);
    check("resume_out", w_out, 0);
    tick();
    check("resume_state2", w_state, 4'b0100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Parametrised successor to the single-bit free-running generator: a multi-mode serial sequence source.
- Modes:
  - Fibonacci LFSR (PRBS) with generic width and tap mask
  - cyclic rotation of a loadable pattern word
  - programmable square wave
- Adds enable, runtime seed/pattern load, lock-up recovery and a period-sync pulse.
- Drives serial stimulus/test lanes; one instance per lane.

Parameters:
- WIDTH, 4: state / pattern register width (>=2).
- TAPS, 4'b1100: feedback mask; bit i set → state[i] enters the XOR. Default is x^4+x^3+1.
- SEED, 4'b0001: reset and fallback LFSR seed. Must be nonzero.
- CNT_W, 8: width of the square-wave half-period counter.

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state to reset values.
- en  in  1  advance enable; when 0 all registers hold.
- mode  in  2  00 LFSR, 01 PATTERN, 10 SQUARE, 11 HOLD.
- load  in  1  synchronous load of load_data; priority over en.
- load_data  in  WIDTH  new seed (LFSR) or new pattern (PATTERN).
- half_period  in  CNT_W  square wave: OUT toggles every half_period+1 enabled cycles.
- OUT  out  1  registered serial output.
- state  out  WIDTH  current state/pattern register (registered).
- sync  out  1  one-cycle pulse at period boundary.
- lockup  out  1  one-cycle pulse when an all-zero LFSR state is recovered.

Behaviour:
- Reset values (async, active-high): state=SEED, seed_r=SEED, OUT=0, sync=0, lockup=0, bit_cnt=0, sq_cnt=0, mode_q=00.
- Cycle priority: reset > load > en. sync and lockup default to 0 every cycle.
- load=1:
  - state<=load_data; bit_cnt<=0; sq_cnt<=0; OUT holds.
  - In LFSR mode seed_r<=load_data. If load_data==0, seed_r and state take SEED instead.
- en=1, LFSR:
  - fb = XOR of (state & TAPS).
  - OUT<=state[WIDTH-1]; state<={state[WIDTH-2:0], fb}.
  - sync=1 when the next state equals seed_r.
  - Latency: the first OUT bit (seed MSB) appears one cycle after the first enabled edge.
- LFSR lock-up: if state==0 while in LFSR mode (reachable only via mode change), then on the next enabled edge state<=seed_r, OUT<=0, lockup=1.
- en=1, PATTERN:
  - OUT<=state[WIDTH-1]; state<={state[WIDTH-2:0], state[WIDTH-1]} (rotate left).
  - bit_cnt increments modulo WIDTH; sync=1 on the edge where bit_cnt wraps WIDTH-1→0.
- en=1, SQUARE:
  - If sq_cnt==half_period: sq_cnt<=0 and OUT<=~OUT; else sq_cnt<=sq_cnt+1.
  - sync=1 on the edge where OUT goes 0→1.
  - half_period==0 gives clk/2.
  - half_period changed mid-count: compared live; if sq_cnt already exceeds the new value, the counter wraps at 2^CNT_W (no early toggle).
  - state holds in this mode.
- HOLD or en=0: everything holds; sync=lockup=0.
- Mode change:
  - mode_q registers mode. On an edge where mode!=mode_q: bit_cnt<=0, sq_cnt<=0, and state and OUT are retained.
  - The new mode's update rule applies on that same edge.
- Reset mid-sequence: immediate return to reset values, independent of clk.

Decomposition:
- Shared package seq_gen_pkg: mode encodings (MODE_LFSR, MODE_PATTERN, MODE_SQUARE, MODE_HOLD) and mode field width 2.
- One natural sub-module: lfsr_step. It is combinational, parametrised by WIDTH and TAPS, and returns next state and fb. It is reused by future multi-lane generators.

Test Plan:
- Defaults; reset pulse; LFSR mode, en=1 for 16 cycles.
  - state visits 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000, then 0001.
  - OUT (lagging one cycle) = 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1.
  - sync pulses exactly once per 15 cycles, when state returns to 0001.
- LFSR, load with load_data=0.
  - state=0001, seed_r=0001.
  - Then load 1010: sync fires when state next returns to 1010, 15 edges later.
- PATTERN mode, load 4'b1000, en=1.
  - OUT=1,0,0,0,1,0,0,0…
  - sync on every 4th enabled edge.
  - Hold en=0 for 3 cycles: OUT and state frozen.
- Lock-up: PATTERN load 0000, switch to LFSR, en=1.
  - Next edge: state=seed_r, lockup=1 for exactly one cycle, OUT=0.
- SQUARE, half_period=2.
  - OUT toggles every 3 enabled edges, giving a period of 6.
  - sync on each 0→1 toggle.
  - half_period=0 gives OUT toggling every edge.
- Assert reset mid-PATTERN, asynchronously between clock edges.
  - state=SEED, OUT=0 immediately.
  - Operation resumes cleanly after reset deassertion.
